seq_scan_ctrl: RTL and testbench

- Controller that feeds a serial overlapping Mealy pattern detector from a parallel word stream.
- Accepts words over a valid/ready handshake and serialises each one, one bit per clock.
- Matches a runtime-programmable pattern of up to PAT_W bits, with overlap allowed.
- Counts matches and raises a sticky interrupt when the count reaches a threshold. Sits between a word-oriented producer and software-visible status.

---
 rtl/seq_scan_pkg.sv | 22 ++
 rtl/seq_scan_if.sv | 21 ++
 rtl/seq_match_core.sv | 86 ++++++++
 rtl/seq_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_scan_pkg
//  Description : Shared types and constants for the serial pattern scanner:
//                controller state encoding and the configuration loaded
//                at reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_scan_pkg;

   // Controller states, explicitly one bit wide
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Configuration in force after reset: pattern 1001, full 4-bit length
   localparam logic [3:0]  C_RST_PATTERN = 4'b1001;
   localparam int unsigned C_RST_LEN     = 4;

endpackage
`default_nettype wire

// File: rtl/seq_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_scan_if
//  Description : Word stream handshake between a producer (master) and the
//                scan controller (slave).
//                valid : word offered by the producer
//                data  : word to scan, held stable until accepted
//                ready : controller can accept a word this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_scan_if #(
   parameter int WORD_W = 8
) ();
   logic              valid;
   logic [WORD_W-1:0] data;
   logic              ready;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_core
//  Description : Overlapping Mealy pattern matcher for one bit per cycle.
//                Keeps the last PAT_W bits (newest at bit 0) and a saturating
//                count of bits seen; raises a registered one-cycle detect the
//                cycle after a matching bit.
//  Ports       : clk, rst_n      clock / async active-low reset
//                bit_valid_i     bit_i carries a new bit this cycle
//                bit_i           incoming bit
//                pattern_i       pattern, bit 0 = most recent bit
//                len_i           pattern length (1..PAT_W, else no match)
//                clear_i         flush history and fill count
//                detect_o        registered match pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_core #(
   parameter int PAT_W = 4,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             bit_valid_i,
   input  wire logic             bit_i,
   input  wire logic [PAT_W-1:0] pattern_i,
   input  wire logic [LEN_W-1:0] len_i,
   input  wire logic             clear_i,
   output logic                  detect_o
);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic             det_q,  det_d;

   logic [PAT_W:0]   w_cat;
   logic [PAT_W-1:0] w_window;
   logic [PAT_W:0]   w_mask_ext;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_seen;
   logic             w_len_ok;
   logic             w_match;

   always_comb begin
      w_cat      = {hist_q, bit_i};
      w_window   = w_cat[PAT_W-1:0];
      // Low len_i bits set; computed one bit wider so len_i == PAT_W works
      w_mask_ext = ((PAT_W+1)'(1) << len_i) - (PAT_W+1)'(1);
      w_mask     = w_mask_ext[PAT_W-1:0];
      // Bits seen including the one arriving now
      w_seen     = {1'b0, fill_q} + (LEN_W+1)'(1);
      w_len_ok   = (len_i != '0) && (len_i <= LEN_W'(PAT_W));
      w_match    = bit_valid_i && w_len_ok && (w_seen >= {1'b0, len_i}) &&
                   (((w_window ^ pattern_i) & w_mask) == '0);

      hist_d = hist_q;
      fill_d = fill_q;
      det_d  = w_match;
      if (clear_i) begin
         hist_d = '0;
         fill_d = '0;
         det_d  = 1'b0;
      end else if (bit_valid_i) begin
         // History survives matches so overlapping occurrences are found
         hist_d = w_window;
         if (fill_q != LEN_W'(PAT_W)) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
      end
   end

   assign detect_o = det_q;

endmodule
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_scan_ctrl
//  Description : Accepts words over a valid/ready stream, serialises them one
//                bit per clock into seq_match_core, counts matches (saturating)
//                and raises a sticky interrupt at a programmable threshold.
//                Optional macro SEQ_SCAN_LSB_FIRST_EN: serialise LSB first
//                (default MSB first).
//  Ports       : clk, rst_n          clock / async active-low reset
//                in_if (slave)       word stream valid/data/ready
//                cfg_we_i            config strobe, honoured in IDLE only
//                cfg_pattern_i       pattern, bit 0 = most recent bit
//                cfg_len_i           pattern length 1..PAT_W
//                cfg_thresh_i        irq threshold, 0 disables
//                clr_count_i         clears match count and irq
//                busy_o              shifting a word
//                bit_out_o           bit consumed this cycle
//                detect_o            registered match pulse
//                match_count_o       saturating match count
//                irq_o               sticky threshold interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 8
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   seq_scan_if.slave                         in_if,
   input  wire logic                         cfg_we_i,
   input  wire logic [PAT_W-1:0]             cfg_pattern_i,
   input  wire logic [$clog2(PAT_W+1)-1:0]   cfg_len_i,
   input  wire logic [CNT_W-1:0]             cfg_thresh_i,
   input  wire logic                         clr_count_i,
   output logic                              busy_o,
   output logic                              bit_out_o,
   output logic                              detect_o,
   output logic [CNT_W-1:0]                  match_count_o,
   output logic                              irq_o
);

   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  sreg_q,   sreg_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [PAT_W-1:0]   pat_q,    pat_d;
   logic [LEN_W-1:0]   len_q,    len_d;
   logic [CNT_W-1:0]   thresh_q, thresh_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               irq_q,    irq_d;

   logic               w_ready;
   logic               w_last;
   logic               w_accept;
   logic               w_cur_bit;
   logic [WORD_W-1:0]  w_shifted;
   logic               w_cfg_load;
   logic               w_det;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign w_last     = (idx_q == IDX_W'(WORD_W - 1));
   assign w_accept   = in_if.valid && w_ready;
   assign w_cfg_load = cfg_we_i && (state_q == ST_IDLE);

`ifdef SEQ_SCAN_LSB_FIRST_EN
   assign w_cur_bit = sreg_q[0];
   assign w_shifted = sreg_q >> 1;
`else
   assign w_cur_bit = sreg_q[WORD_W-1];
   assign w_shifted = sreg_q << 1;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (w_accept)            state_d = ST_SHIFT;
         ST_SHIFT: if (w_last && !w_accept) state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_ready   = 1'b0;
      busy_o    = 1'b0;
      bit_out_o = 1'b0;
      case (state_q)
         ST_IDLE:  w_ready = 1'b1;
         ST_SHIFT: begin
            // Ready on the last bit lets the next word follow with no gap
            w_ready   = w_last;
            busy_o    = 1'b1;
            bit_out_o = w_cur_bit;
         end
         default:  w_ready = 1'b0;
      endcase
   end

   assign in_if.ready = w_ready;

   // ---------------- Datapath next-state ----------------
   always_comb begin
      sreg_d   = sreg_q;
      idx_d    = idx_q;
      pat_d    = pat_q;
      len_d    = len_q;
      thresh_d = thresh_q;
      cnt_d    = cnt_q;
      irq_d    = irq_q;
      w_cnt_inc = cnt_q + CNT_W'(1);

      if (w_accept) begin
         sreg_d = in_if.data;
         idx_d  = '0;
      end else if (state_q == ST_SHIFT) begin
         sreg_d = w_shifted;
         idx_d  = idx_q + IDX_W'(1);
      end

      if (w_cfg_load) begin
         pat_d    = cfg_pattern_i;
         len_d    = cfg_len_i;
         thresh_d = cfg_thresh_i;
      end

      // Clear wins over a coincident detect, which still counts as one
      if (clr_count_i) begin
         cnt_d = {{(CNT_W-1){1'b0}}, w_det};
         irq_d = 1'b0;
      end else if (w_det && (cnt_q != '1)) begin
         cnt_d = w_cnt_inc;
         if ((thresh_q != '0) && (w_cnt_inc == thresh_q)) begin
            irq_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q   <= '0;
         idx_q    <= '0;
         pat_q    <= PAT_W'(C_RST_PATTERN);
         len_q    <= LEN_W'(C_RST_LEN);
         thresh_q <= '0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         sreg_q   <= sreg_d;
         idx_q    <= idx_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         thresh_q <= thresh_d;
         cnt_q    <= cnt_d;
         irq_q    <= irq_d;
      end
   end

   seq_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_match (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_valid_i (state_q == ST_SHIFT),
      .bit_i       (w_cur_bit),
      .pattern_i   (pat_q),
      .len_i       (len_q),
      .clear_i     (w_cfg_load),
      .detect_o    (w_det)
   );

   assign detect_o      = w_det;
   assign match_count_o = cnt_q;
   assign irq_o         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_scan_ctrl
//  Description : Self-checking bench for seq_scan_ctrl. A bit-level reference
//                model queues the expected bit and detect for every word as it
//                is offered; a negedge monitor pops and compares them and
//                tracks the expected count and irq cycle by cycle. A second
//                instance with CNT_W=2 shares the stimulus to show saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_pattern = 4'b1001;
   logic [2:0] cfg_len = 3'd4;
   logic [7:0] cfg_thresh = 8'd0;
   logic       clr_count = 1'b0;

   logic       busy, bit_out, detect, irq;
   logic [7:0] count;
   logic       busy2, bit_out2, detect2, irq2;
   logic [1:0] count2;

   always #5 clk = ~clk;

   seq_scan_if #(.WORD_W(8)) bus  ();
   seq_scan_if #(.WORD_W(8)) bus2 ();
   assign bus2.valid = bus.valid;
   assign bus2.data  = bus.data;

   seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_if(bus),
      .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
      .cfg_thresh_i(cfg_thresh), .clr_count_i(clr_count),
      .busy_o(busy), .bit_out_o(bit_out), .detect_o(detect),
      .match_count_o(count), .irq_o(irq)
   );

   seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_if(bus2),
      .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
      .cfg_thresh_i(2'b00), .clr_count_i(clr_count),
      .busy_o(busy2), .bit_out_o(bit_out2), .detect_o(detect2),
      .match_count_o(count2), .irq_o(irq2)
   );

   int total = 0;
   int bad   = 0;

   // Scoreboard and reference model state
   logic q_bit[$];
   logic q_det[$];
   logic [3:0] m_hist;
   int         m_fill, m_len, m_thresh, m_cnt, m_cnt2;
   logic [3:0] m_pat;
   logic       m_irq;
   logic       pend, pend_det;
   logic       mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hist = 4'b0; m_fill = 0; m_pat = 4'b1001; m_len = 4; m_thresh = 0;
      m_cnt = 0; m_cnt2 = 0; m_irq = 1'b0; pend = 1'b0; pend_det = 1'b0;
      q_bit.delete(); q_det.delete();
   endtask

   // Walk a word through the matcher model bit by bit
   task automatic model_word(input logic [7:0] d);
      logic b, hit;
      logic [3:0] win;
      for (int k = 0; k < 8; k++) begin
`ifdef SEQ_SCAN_LSB_FIRST_EN
         b = d[k];
`else
         b = d[7-k];
`endif
         win = {m_hist[2:0], b};
         hit = (m_len >= 1) && (m_len <= 4) && (m_fill + 1 >= m_len);
         for (int j = 0; j < 4; j++) begin
            if (j < m_len && win[j] != m_pat[j]) hit = 1'b0;
         end
         q_bit.push_back(b);
         q_det.push_back(hit);
         m_hist = win;
         if (m_fill < 4) m_fill++;
      end
   endtask

   // Monitor: compare outputs mid-cycle, then advance the count model
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         logic exp_d;
         exp_d = pend ? pend_det : 1'b0;
         chk("detect", {31'b0, detect}, {31'b0, exp_d});
         chk("count", {24'b0, count}, m_cnt);
         chk("irq", {31'b0, irq}, {31'b0, m_irq});
         chk("count2", {30'b0, count2}, m_cnt2);
         chk("irq2", {31'b0, irq2}, 32'd0);
         if (clr_count) begin
            m_cnt = exp_d; m_cnt2 = exp_d; m_irq = 1'b0;
         end else if (exp_d) begin
            if (m_cnt < 255) begin
               m_cnt++;
               if (m_thresh != 0 && m_cnt == m_thresh) m_irq = 1'b1;
            end
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (busy === 1'b1) begin
            if (q_bit.size() == 0) begin
               chk("unexpected_bit", 32'd1, 32'd0);
               pend = 1'b0;
            end else begin
               logic eb;
               eb = q_bit.pop_front();
               pend_det = q_det.pop_front();
               pend = 1'b1;
               chk("bit_out", {31'b0, bit_out}, {31'b0, eb});
            end
         end else begin
            pend = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] d, output logic acc_busy);
      int n;
      bit ok;
      n = 0; ok = 0;
      bus.valid = 1'b1;
      bus.data  = d;
      while (!ok && n < 100) begin
         @(negedge clk);
         if (bus.ready === 1'b1) ok = 1; else n++;
      end
      acc_busy = busy;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      else model_word(d);
      @(posedge clk); #1;
      bus.valid = 1'b0;
   endtask

   task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic [7:0] t,
                      input bit applies);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (applies) begin
         m_pat = p; m_len = int'(l); m_thresh = int'(t); m_hist = 4'b0; m_fill = 0;
      end
   endtask

   task automatic clr();
      clr_count = 1'b1;
      @(posedge clk); #1;
      clr_count = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy === 1'b1 || q_bit.size() != 0 || pend) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"},  {31'b0, bus.ready}, 32'd1);
      chk({tag, "_busy"},   {31'b0, busy},      32'd0);
      chk({tag, "_bitout"}, {31'b0, bit_out},   32'd0);
      chk({tag, "_detect"}, {31'b0, detect},    32'd0);
      chk({tag, "_count"},  {24'b0, count},     32'd0);
      chk({tag, "_irq"},    {31'b0, irq},       32'd0);
      chk({tag, "_count2"}, {30'b0, count2},    32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic b1, b2;
      bus.valid = 1'b0;
      bus.data  = 8'h00;
      model_reset();

      // Reset state
      #12;
      chk_reset_vals("rst");
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Default config: 0100_1001 matches on bits 4 and 7 (overlap)
      send(8'h49, b1);
      drain();
      chk("t1_count", {24'b0, count}, 32'd2);
      clr();

      // Back-to-back words; the second is accepted while still shifting
      send(8'h09, b1);
      send(8'h20, b2);
      chk("t2_b2b_busy", {31'b0, b2}, 32'd1);
      drain();
      chk("t2_count", {24'b0, count}, m_cnt);
      clr();

      // Two-bit pattern 11, threshold 3, all-ones word: 7 matches
      cfg(4'b0011, 3'd2, 8'd3, 1'b1);
      send(8'hFF, b1);
      drain();
      chk("t3_count", {24'b0, count}, 32'd7);
      chk("t3_irq", {31'b0, irq}, 32'd1);
      chk("t3_count2_sat", {30'b0, count2}, 32'd3);
      clr();

      // Config write while busy is ignored; in IDLE it applies and flushes history
      cfg(4'b1001, 3'd4, 8'd0, 1'b1);
      send(8'h00, b1);
      cfg(4'b0010, 3'd2, 8'd0, 1'b0);
      send(8'h99, b1);
      drain();
      chk("t4_old_pattern", {24'b0, count}, 32'd2);
      cfg(4'b0010, 3'd2, 8'd0, 1'b1);
      send(8'h00, b1);
      drain();
      chk("t4_no_cross_cfg", {24'b0, count}, 32'd2);

      // Clear coincident with a detect leaves the count at 1 and irq low
      cfg(4'b1001, 3'd4, 8'd1, 1'b1);
      clr();
      send(8'h09, b1);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_detect_high", {31'b0, detect}, 32'd1);
      clr_count = 1'b1;
      @(posedge clk); #1;
      clr_count = 1'b0;
      chk("t5_count", {24'b0, count}, 32'd1);
      chk("t5_irq", {31'b0, irq}, 32'd0);
      drain();

      // Asynchronous reset in the middle of a word
      send(8'hFF, b1);
      repeat (3) @(posedge clk);
      #2;
      rst_n  = 1'b0;
      mon_en = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      model_reset();
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      // Stale all-ones history would match 1001 on bit 2 of 0010_0000
      send(8'h20, b1);
      drain();
      chk("t6_count", {24'b0, count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
